// File: rtl/reg_context_sequencer.sv
// Context-switch sequencer: streams registers FIRST_REG..LAST_REG out to a save
// image in data memory, then optionally reloads them from a restore image.
module reg_context_sequencer #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 63,
  parameter int ADDR_W    = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [ADDR_W-1:0] Save_Base,
  input  logic [ADDR_W-1:0] Restore_Base,
  output logic              Busy,
  output logic              Done,
  output logic [5:0]        Rf_Read_Sel,
  input  logic [31:0]       Rf_Read_Data,
  output logic              Rf_Write_En,
  output logic [5:0]        Rf_Write_Sel,
  output logic [31:0]       Rf_Write_Data,
  output logic              Mem_Req,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wdata,
  input  logic [31:0]       Mem_Rdata,
  input  logic              Mem_Ack
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAVE       = 3'd1,
    ST_RESTORE_RD = 3'd2,
    ST_RESTORE_WR = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam logic [5:0] FIRST_IDX = 6'(FIRST_REG);
  localparam logic [5:0] LAST_IDX  = 6'(LAST_REG);

  state_t            state_r;
  state_t            state_next_s;
  logic [5:0]        index_r;
  logic              restore_r;
  logic [ADDR_W-1:0] save_base_r;
  logic [ADDR_W-1:0] restore_base_r;
  logic [31:0]       wdata_r;
  logic              last_s;
  logic [ADDR_W-1:0] offset_s;

  assign last_s   = (index_r == LAST_IDX);
  // index never drops below FIRST_IDX, so the 6-bit difference is exact
  assign offset_s = {{(ADDR_W-6){1'b0}}, index_r - FIRST_IDX};

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Captured request, register index and restore data latch
  always_ff @(posedge Clock) begin
    if (Reset) begin
      index_r        <= FIRST_IDX;
      restore_r      <= 1'b0;
      save_base_r    <= {ADDR_W{1'b0}};
      restore_base_r <= {ADDR_W{1'b0}};
      wdata_r        <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start && (Op != 2'b00)) begin
            restore_r      <= Op[1];
            save_base_r    <= Save_Base;
            restore_base_r <= Restore_Base;
            index_r        <= FIRST_IDX;
          end
        end
        ST_SAVE: begin
          if (Mem_Ack) begin
            index_r <= last_s ? FIRST_IDX : index_r + 6'd1;
          end
        end
        ST_RESTORE_RD: begin
          if (Mem_Ack) begin
            wdata_r <= Mem_Rdata;
          end
        end
        ST_RESTORE_WR: begin
          if (!last_s) begin
            index_r <= index_r + 6'd1;
          end
        end
        ST_DONE: index_r <= FIRST_IDX;
        default: index_r <= FIRST_IDX;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start && (Op != 2'b00)) begin
          state_next_s = Op[0] ? ST_SAVE : ST_RESTORE_RD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SAVE: begin
        if (Mem_Ack && last_s) begin
          state_next_s = restore_r ? ST_RESTORE_RD : ST_DONE;
        end else begin
          state_next_s = ST_SAVE;
        end
      end
      ST_RESTORE_RD: begin
        if (Mem_Ack) begin
          state_next_s = ST_RESTORE_WR;
        end else begin
          state_next_s = ST_RESTORE_RD;
        end
      end
      ST_RESTORE_WR: state_next_s = last_s ? ST_DONE : ST_RESTORE_RD;
      ST_DONE:       state_next_s = ST_IDLE;
      default:       state_next_s = ST_IDLE;
    endcase
  end

  // Output decode; everything is zero in IDLE
  always_comb begin
    Busy          = 1'b1;
    Done          = 1'b0;
    Rf_Read_Sel   = 6'd0;
    Rf_Write_En   = 1'b0;
    Rf_Write_Sel  = 6'd0;
    Rf_Write_Data = 32'd0;
    Mem_Req       = 1'b0;
    Mem_Write     = 1'b0;
    Mem_Addr      = {ADDR_W{1'b0}};
    Mem_Wdata     = 32'd0;
    case (state_r)
      ST_IDLE: Busy = 1'b0;
      ST_SAVE: begin
        Mem_Req     = 1'b1;
        Mem_Write   = 1'b1;
        Mem_Addr    = save_base_r + offset_s;
        Rf_Read_Sel = index_r;
        Mem_Wdata   = Rf_Read_Data;
      end
      ST_RESTORE_RD: begin
        Mem_Req  = 1'b1;
        Mem_Addr = restore_base_r + offset_s;
      end
      ST_RESTORE_WR: begin
        // register 0 is hard-wired; its write slot is spent but suppressed
        Rf_Write_En   = (index_r != 6'd0);
        Rf_Write_Sel  = index_r;
        Rf_Write_Data = wdata_r;
      end
      ST_DONE: Done = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Scoreboard bench for reg_context_sequencer: a transaction-level model predicts
// the memory/bank traffic, a monitor pops and compares it as the DUT produces it.
module tb_reg_context_sequencer;

  localparam int FIRST = 1;
  localparam int LAST  = 63;
  localparam int EV_MW = 0, EV_MR = 1, EV_RW = 2, EV_DN = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        Clock, Reset, Start;
  logic [1:0]  Op;
  logic [31:0] Save_Base, Restore_Base;
  logic        Busy, Done;
  logic [5:0]  Rf_Read_Sel;
  logic [31:0] Rf_Read_Data;
  logic        Rf_Write_En;
  logic [5:0]  Rf_Write_Sel;
  logic [31:0] Rf_Write_Data;
  logic        Mem_Req, Mem_Write;
  logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
  logic        Mem_Ack;

  reg_context_sequencer #(.FIRST_REG(FIRST), .LAST_REG(LAST), .ADDR_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .Save_Base(Save_Base), .Restore_Base(Restore_Base),
    .Busy(Busy), .Done(Done),
    .Rf_Read_Sel(Rf_Read_Sel), .Rf_Read_Data(Rf_Read_Data),
    .Rf_Write_En(Rf_Write_En), .Rf_Write_Sel(Rf_Write_Sel), .Rf_Write_Data(Rf_Write_Data),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack)
  );

  // environment: register bank, 4K-word memory, reference copies of both
  logic [31:0] bank [64];
  logic [31:0] mem [4096];
  logic [31:0] ref_bank [64];
  logic [31:0] ref_mem [4096];
  ev_t         sb_q [$];
  int          n_tests = 0, n_fail = 0;
  bit          ack_tied = 1'b1;
  int          stall_left = 0;
  logic        ld_en = 1'b0, ld_bank = 1'b0;
  logic [31:0] ld_addr = 32'd0, ld_data = 32'd0;
  logic        prev_stall = 1'b0, prev_write = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;

  assign Rf_Read_Data = bank[Rf_Read_Sel];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // bank/memory writes: preloads from the bench and transfers from the DUT
  always @(posedge Clock) begin
    if (ld_en) begin
      if (ld_bank) bank[ld_addr[5:0]] <= ld_data;
      else         mem[ld_addr[11:0]] <= ld_data;
    end
    if (Rf_Write_En) bank[Rf_Write_Sel] <= Rf_Write_Data;
    if (Mem_Req && Mem_Ack && Mem_Write) mem[Mem_Addr[11:0]] <= Mem_Wdata;
  end

  // memory responder: tied ack, or 0-3 random wait states plus stray acks when idle
  always @(negedge Clock) begin
    Mem_Rdata = mem[Mem_Addr[11:0]];
    if (ack_tied) begin
      Mem_Ack = 1'b1;
    end else if (!Mem_Req) begin
      Mem_Ack = 1'($urandom_range(0, 1));
    end else if (stall_left > 0) begin
      Mem_Ack = 1'b0;
      stall_left--;
    end else begin
      Mem_Ack = 1'b1;
      stall_left = $urandom_range(0, 3);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none", kind, a, d);
    end else begin
      e = sb_q.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_addr", a, e.a);
      chk("ev_data", d, e.d);
    end
  endtask

  // monitor: compares every transfer, register write and Done against the queue
  always @(negedge Clock) begin
    #1;
    if (!Reset) begin
      if (prev_stall) begin
        chk("stall_req", 32'(Mem_Req), 32'd1);
        chk("stall_addr", Mem_Addr, prev_addr);
        chk("stall_write", 32'(Mem_Write), 32'(prev_write));
        chk("stall_wdata", Mem_Wdata, prev_wdata);
      end
      if (Mem_Req && Mem_Ack)
        expect_ev(Mem_Write ? EV_MW : EV_MR, Mem_Addr, Mem_Write ? Mem_Wdata : 32'd0);
      if (Rf_Write_En) begin
        chk("reg0_protect", 32'(Rf_Write_Sel != 6'd0), 32'd1);
        expect_ev(EV_RW, 32'(Rf_Write_Sel), Rf_Write_Data);
      end
      if (Done) expect_ev(EV_DN, 32'd0, 32'd0);
      prev_stall = Mem_Req && !Mem_Ack;
      prev_addr  = Mem_Addr;
      prev_write = Mem_Write;
      prev_wdata = Mem_Wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load(input bit to_bank, input logic [31:0] a, input logic [31:0] d);
    @(negedge Clock);
    ld_en = 1'b1; ld_bank = to_bank; ld_addr = a; ld_data = d;
    if (to_bank) ref_bank[a[5:0]] = d;
    else         ref_mem[a[11:0]] = d;
  endtask

  task automatic load_end();
    @(negedge Clock);
    ld_en = 1'b0;
  endtask

  task automatic check_bank(input string name);
    for (int k = 0; k < 64; k++) chk(name, bank[k], ref_bank[k]);
  endtask

  // model: saves stream the bank out in order, then each restore is a read and a write
  task automatic run_op(input logic [1:0] op, input logic [31:0] sb, input logic [31:0] rb,
                        input int exp_lat, input bit poke);
    int          cnt, done_at;
    logic [31:0] a;
    if (op[0]) begin
      for (int k = FIRST; k <= LAST; k++) begin
        a = sb + 32'(k - FIRST);
        sb_q.push_back('{EV_MW, a, ref_bank[k]});
        ref_mem[a[11:0]] = ref_bank[k];
      end
    end
    if (op[1]) begin
      for (int k = FIRST; k <= LAST; k++) begin
        a = rb + 32'(k - FIRST);
        sb_q.push_back('{EV_MR, a, 32'd0});
        if (k != 0) begin
          sb_q.push_back('{EV_RW, 32'(k), ref_mem[a[11:0]]});
          ref_bank[k] = ref_mem[a[11:0]];
        end
      end
    end
    sb_q.push_back('{EV_DN, 32'd0, 32'd0});
    @(negedge Clock);
    Start = 1'b1; Op = op; Save_Base = sb; Restore_Base = rb;
    @(negedge Clock);
    Start = 1'b0; Op = 2'b00; Save_Base = $urandom; Restore_Base = $urandom;
    cnt = 0; done_at = 0;
    forever begin
      #2;
      if (!Busy) break;
      cnt++;
      if (Done) done_at = cnt;
      if (poke && cnt == 5) begin Start = 1'b1; Op = 2'b11; end
      else begin Start = 1'b0; Op = 2'b00; end
      if (cnt >= 5000) begin
        n_tests++; n_fail++;
        $display("FAIL busy_timeout: got %0d busy cycles, expected completion", cnt);
        break;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    if (exp_lat > 0) chk("busy_cycles", 32'(cnt), 32'(exp_lat));
    chk("done_cycle", 32'(done_at), 32'(cnt));
    repeat (2) @(negedge Clock);
    #2;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    check_bank("bank_after_op");
  endtask

  initial begin
    logic [31:0] sb, rb;
    bit          found;
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; Save_Base = 32'd0; Restore_Base = 32'd0;
    Mem_Ack = 1'b0; Mem_Rdata = 32'd0;
    for (int k = 0; k < 64; k++) ref_bank[k] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
    for (int k = 0; k < 64; k++) load(1'b1, 32'(k), 32'(k * 3));
    for (int i = 0; i < 4096; i += 64) load(1'b0, 32'(i), 32'd0);
    load_end();
    for (int i = 0; i < 4096; i++) if (i % 64 != 0) mem[i] = 32'd0;
    #2;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_mem_req", 32'(Mem_Req), 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    chk("rst_rf_we", 32'(Rf_Write_En), 32'd0);
    chk("rst_rf_rsel", 32'(Rf_Read_Sel), 32'd0);
    Reset = 1'b0;

    // Start with Op=00 is a no-op
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; Save_Base = 32'h40; Restore_Base = 32'h80;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) begin
      #2;
      chk("op00_idle", 32'(Busy), 32'd0);
      @(negedge Clock);
    end

    run_op(2'b01, 32'h0000_0100, 32'd0, 64, 1'b0);
    for (int i = 0; i < 63; i++) load(1'b0, 32'h200 + 32'(i), 32'hA000 + 32'(i));
    load_end();
    run_op(2'b10, 32'd0, 32'h0000_0200, 127, 1'b0);
    run_op(2'b11, 32'h0000_0100, 32'h0000_0200, 190, 1'b1);

    ack_tied = 1'b0;
    for (int r = 0; r < 3; r++) begin
      sb = ($urandom & 32'hFFFF_F000) | 32'h400;
      rb = ($urandom & 32'hFFFF_F000) | 32'h800;
      for (int k = 1; k < 64; k++) load(1'b1, 32'(k), $urandom);
      for (int i = 0; i < 63; i++) load(1'b0, rb + 32'(i), $urandom);
      load_end();
      run_op(2'b11, sb, rb, 0, 1'b1);
    end
    ack_tied = 1'b1;

    run_op(2'b01, 32'hFFFF_FFF0, 32'd0, 64, 1'b0);

    // reset while the read for register 20 is on the bus
    for (int i = 0; i < 63; i++) load(1'b0, 32'h300 + 32'(i), 32'hB000 + 32'(i));
    load_end();
    for (int k = 1; k < 20; k++) begin
      sb_q.push_back('{EV_MR, 32'h300 + 32'(k - 1), 32'd0});
      sb_q.push_back('{EV_RW, 32'(k), 32'hB000 + 32'(k - 1)});
      ref_bank[k] = 32'hB000 + 32'(k - 1);
    end
    sb_q.push_back('{EV_MR, 32'h313, 32'd0});
    @(negedge Clock);
    Start = 1'b1; Op = 2'b10; Save_Base = 32'd0; Restore_Base = 32'h300;
    @(negedge Clock);
    Start = 1'b0; Op = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #2;
      if (Mem_Req && !Mem_Write && Mem_Addr == 32'h313) begin
        found = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    chk("rd20_reached", 32'(found), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    #2;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_mem_req", 32'(Mem_Req), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_rf_we", 32'(Rf_Write_En), 32'd0);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      #2;
      chk("abort_no_done", 32'(Done), 32'd0);
      chk("abort_idle", 32'(Busy), 32'd0);
    end
    chk("abort_sb_empty", 32'(sb_q.size()), 32'd0);
    check_bank("bank_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
